// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader for the CPU instruction memory
module program_loader #(
  parameter int         INSTRUCTION_WIDTH = 13,
  parameter int         PC_WIDTH          = 4,
  parameter logic [7:0] SYNC_BYTE         = 8'hA5
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic [7:0]                   byteIn,
  input  logic                         byteValid,
  output logic                         byteReady,
  output logic                         wrEn,
  output logic [PC_WIDTH-1:0]          wrAddr,
  output logic [INSTRUCTION_WIDTH-1:0] wrData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic                         loadError
);

  // A full memory load (COUNT == depth) is legal, so COUNT is range-checked
  // in 9 bits and the count/address registers carry one extra bit.
  localparam logic [8:0] MAX_COUNT = 9'(2 ** PC_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HIGH, S_LOW, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                       state, next_state;
  logic [PC_WIDTH:0]            count, addr, addr_inc;
  logic [INSTRUCTION_WIDTH-9:0] high_bits;
  logic [7:0]                   checksum;
  logic [PC_WIDTH-1:0]          wr_addr_q;
  logic [INSTRUCTION_WIDTH-1:0] wr_data_q;
  logic [8:0]                   byte_ext;
  logic                         take, is_sync, count_bad;

  assign take      = byteValid && byteReady;
  assign is_sync   = (byteIn == SYNC_BYTE);
  assign byte_ext  = {1'b0, byteIn};
  assign count_bad = (byteIn == 8'd0) || (byte_ext > MAX_COUNT);
  assign addr_inc  = addr + {{PC_WIDTH{1'b0}}, 1'b1};

  // State register; reset drops any in-flight write and releases the CPU.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state: frame parsing, only advancing on an accepted byte (WRITE is unconditional).
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (take && is_sync) next_state = S_COUNT;
      S_COUNT: if (take) next_state = count_bad ? S_ERROR : S_HIGH;
      S_HIGH:  if (take) next_state = S_LOW;
      S_LOW:   if (take) next_state = S_WRITE;
      S_WRITE: next_state = (addr_inc == count) ? S_CHECK : S_HIGH;
      S_CHECK: if (take) next_state = (byteIn == checksum) ? S_DONE : S_ERROR;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from state; status holds until the next SYNC leaves DONE/ERROR.
  always_comb begin
    byteReady = (state != S_WRITE);
    wrEn      = (state == S_WRITE);
    cpuHold   = (state != S_IDLE) && (state != S_DONE);
    loadDone  = (state == S_DONE);
    loadError = (state == S_ERROR);
    wrAddr    = wr_addr_q;
    wrData    = wr_data_q;
  end

  // Datapath: count, address, checksum and the staged write word.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count     <= '0;
      addr      <= '0;
      high_bits <= '0;
      checksum  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (take && is_sync) checksum <= '0;
        end
        S_COUNT: begin
          if (take && !count_bad) begin
            count    <= byte_ext[PC_WIDTH:0];
            checksum <= byteIn;
            addr     <= '0;
          end
        end
        S_HIGH: begin
          if (take) begin
            high_bits <= byteIn[INSTRUCTION_WIDTH-9:0];
            checksum  <= checksum + byteIn;
          end
        end
        S_LOW: begin
          if (take) begin
            checksum  <= checksum + byteIn;
            wr_data_q <= {high_bits, byteIn};
            wr_addr_q <= addr[PC_WIDTH-1:0];
          end
        end
        S_WRITE: addr <= addr_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam int         IW    = 13;
  localparam int         PW    = 4;
  localparam int         DEPTH = 1 << PW;
  localparam logic [7:0] SYNC  = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic [7:0]    byteIn = 8'h00;
  logic          byteValid = 1'b0;
  logic          byteReady, wrEn, cpuHold, loadDone, loadError;
  logic [PW-1:0] wrAddr;
  logic [IW-1:0] wrData;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] act_addr[$];
  logic [IW-1:0] act_data[$];
  int            ready_low;

  logic [PW-1:0] exp_addr[$];
  logic [IW-1:0] exp_data[$];
  logic          exp_done, exp_err, exp_hold;

  program_loader #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .SYNC_BYTE(SYNC)) dut (
    .clock(clock), .resetN(resetN), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clock = ~clock;

  // Capture every memory write and every stalled cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (wrEn === 1'b1) begin
      act_addr.push_back(wrAddr);
      act_data.push_back(wrData);
    end
    if (byteReady === 1'b0) ready_low++;
  end

  // Reference: decode one frame straight from the byte list.
  task automatic model_frame(input bq_t q);
    int          s;
    int          cnt;
    logic [7:0]  sum;
    logic [15:0] word;
    s = -1;
    foreach (q[i]) if (s < 0 && q[i] == SYNC) s = i;
    exp_addr.delete();
    exp_data.delete();
    cnt = int'(q[s+1]);
    if (cnt == 0 || cnt > DEPTH) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_hold = 1'b1;
      return;
    end
    sum = q[s+1];
    for (int k = 0; k < cnt; k++) begin
      word = {q[s+2+2*k], q[s+3+2*k]};
      exp_addr.push_back(PW'(k));
      exp_data.push_back(word[IW-1:0]);
      sum = sum + q[s+2+2*k] + q[s+3+2*k];
    end
    exp_done = (q[s+2+2*cnt] == sum);
    exp_err  = !exp_done;
    exp_hold = !exp_done;
  endtask

  task automatic make_frame(input int cnt, input bit corrupt, output bq_t q);
    logic [7:0] sum, hi, lo;
    q = {};
    q.push_back(SYNC);
    q.push_back(8'(cnt));
    sum = 8'(cnt);
    for (int k = 0; k < cnt; k++) begin
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      q.push_back(hi);
      q.push_back(lo);
      sum = sum + hi + lo;
    end
    if (corrupt) sum = sum + 8'($urandom_range(1, 255));
    q.push_back(sum);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited;
    if (stall) repeat ($urandom_range(0, 3)) @(negedge clock);
    byteIn    = b;
    byteValid = 1'b1;
    waited    = 0;
    while (byteReady !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 20) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: byte %0h never accepted", b);
    end else begin
      @(posedge clock);
      @(negedge clock);
    end
    byteValid = 1'b0;
  endtask

  task automatic run_frame(input bq_t q, input bit stall, input string name);
    bit seen;
    int n;
    model_frame(q);
    act_addr.delete();
    act_data.delete();
    ready_low = 0;
    seen = 1'b0;
    foreach (q[i]) begin
      send_byte(q[i], stall);
      if (!seen && q[i] == SYNC) begin
        seen = 1'b1;
        checks++;
        if (cpuHold !== 1'b1 || loadDone !== 1'b0 || loadError !== 1'b0) begin
          errors++;
          $display("FAIL %s_after_sync: hold/done/err got %b%b%b expected 100", name, cpuHold, loadDone, loadError);
        end
      end
    end
    repeat (2) @(negedge clock);
    checks++;
    if (act_addr.size() !== exp_addr.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d expected %0d", name, act_addr.size(), exp_addr.size());
    end
    n = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (act_addr[k] !== exp_addr[k] || act_data[k] !== exp_data[k]) begin
        errors++;
        $display("FAIL %s_write%0d: got %0h@%0h expected %0h@%0h", name, k, act_data[k], act_addr[k], exp_data[k], exp_addr[k]);
      end
    end
    checks++;
    if (loadDone !== exp_done || loadError !== exp_err || cpuHold !== exp_hold) begin
      errors++;
      $display("FAIL %s_status: done/err/hold got %b%b%b expected %b%b%b", name, loadDone, loadError, cpuHold, exp_done, exp_err, exp_hold);
    end
    checks++;
    if (ready_low !== exp_addr.size()) begin
      errors++;
      $display("FAIL %s_ready_low_cycles: got %0d expected %0d", name, ready_low, exp_addr.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (byteReady !== 1'b1 || wrEn !== 1'b0 || wrAddr !== '0 || wrData !== '0 ||
        cpuHold !== 1'b0 || loadDone !== 1'b0 || loadError !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy/we/addr/data/hold/done/err got %b %b %0h %0h %b %b %b expected 1 0 0 0 0 0 0",
               name, byteReady, wrEn, wrAddr, wrData, cpuHold, loadDone, loadError);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset_values");
    resetN = 1'b1;
    @(negedge clock);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_good_load();
    run_frame({SYNC, 8'h02, 8'h01, 8'h23, 8'h07, 8'h45, 8'h72}, 1'b0, "good_load");
    checks++;
    if (act_data.size() != 2 || act_data[0] !== 13'h123 || act_data[1] !== 13'h745) begin
      errors++;
      $display("FAIL good_load_words: got %p expected 123,745", act_data);
    end
  endtask

  task automatic test_bad_checksum();
    run_frame({SYNC, 8'h01, 8'h00, 8'h11, 8'h00}, 1'b0, "bad_checksum");
    run_frame({SYNC, 8'h02, 8'h01, 8'h23, 8'h07, 8'h45, 8'h72}, 1'b0, "recover_after_error");
  endtask

  task automatic test_count_limits();
    bq_t q;
    run_frame({SYNC, 8'h00}, 1'b0, "count_zero");
    run_frame({SYNC, 8'h11}, 1'b0, "count_over");
    make_frame(DEPTH, 1'b0, q);
    run_frame(q, 1'b0, "count_full");
  endtask

  task automatic test_idle_filter();
    run_frame({8'hFF, 8'h3C, SYNC, 8'h01, SYNC, SYNC, 8'h4B}, 1'b0, "idle_filter");
    checks++;
    if (act_data.size() != 1 || act_data[0] !== 13'h05A5) begin
      errors++;
      $display("FAIL idle_filter_word: got %p expected 5a5", act_data);
    end
  endtask

  task automatic test_stalls();
    bq_t q;
    run_frame({SYNC, 8'h02, 8'h01, 8'h23, 8'h07, 8'h45, 8'h72}, 1'b1, "stall_good_load");
    for (int t = 0; t < 4; t++) begin
      make_frame($urandom_range(1, DEPTH), ($urandom_range(0, 2) == 0), q);
      run_frame(q, 1'b1, "stall_random");
    end
  endtask

  task automatic test_midframe_reset();
    act_addr.delete();
    send_byte(SYNC, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h01, 1'b0);
    resetN = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_reset_outputs("midframe_reset_values");
    @(negedge clock);
    checks++;
    if (act_addr.size() !== 0) begin
      errors++;
      $display("FAIL midframe_reset_no_write: got %0d writes expected 0", act_addr.size());
    end
    resetN = 1'b1;
    @(negedge clock);
    run_frame({SYNC, 8'h02, 8'h01, 8'h23, 8'h07, 8'h45, 8'h72}, 1'b0, "after_midframe_reset");
  endtask

  task automatic test_back_to_back();
    bq_t q;
    for (int t = 0; t < 6; t++) begin
      make_frame($urandom_range(1, DEPTH), ($urandom_range(0, 2) == 0), q);
      run_frame(q, 1'b0, "back_to_back");
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_count_limits();
    test_idle_filter();
    test_stalls();
    test_midframe_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
